// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer request lanes, FIFO write-side signals and grant status
// shared by the round-robin write arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GID_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic [GID_W-1:0]              grant_id;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          busy;

  // Environment side: producers plus the FIFO full flag.
  modport master (
    output req, req_data, full,
    input  gnt, ack, grant_id, wr_en, wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, full,
    output gnt, ack, grant_id, wr_en, wdata, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers;
// each grant lasts at most MAX_BURST beats and writes are gated by full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic             wr_clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [GID_W-1:0]     grant_id_q, grant_id_d;
  logic [GID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic                  found;
  logic [GID_W-1:0]      pick;
  logic [GID_W-1:0]      next_ptr;
  logic                  owner_req;
  logic                  wr_en;
  logic                  last_beat;
  logic                  release_now;
  logic [DATA_WIDTH-1:0] lanes [NUM_REQ];

  // Two passes: first the indices at or above rr_ptr, then wrap to the bottom.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && GID_W'(j) >= rr_ptr_q && bus.req[j]) begin
        found = 1'b1;
        pick  = GID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = GID_W'(j);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      lanes[j] = bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_req   = bus.req[grant_id_q];
  assign wr_en       = (state_q == OWN) && owner_req && !bus.full;
  assign last_beat   = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_now = !owner_req || (wr_en && last_beat);
  assign next_ptr    = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  assign bus.wr_en    = wr_en;
  assign bus.ack      = gnt_q & {NUM_REQ{wr_en}};
  assign bus.wdata    = (state_q == OWN) ? lanes[grant_id_q] : '0;
  assign bus.gnt      = gnt_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q == OWN);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = OWN;
          gnt_d      = NUM_REQ'(1) << pick;
          grant_id_d = pick;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        // grant_id keeps the last owner after release; only gnt clears.
        if (release_now) begin
          state_d    = IDLE;
          gnt_d      = '0;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (wr_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table for single-cycle behaviour
// plus hand-written multi-cycle sequences with a small producer/ownership monitor.
module tb_fifo_wr_arbiter;
  logic wr_clk;
  logic rst;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic [3:0]  req;
    logic        full;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  gid;
  } vec_t;

  int nChecks = 0;
  int nFail   = 0;

  int sent [4];
  logic [3:0] prevGnt;
  int burstAcks;
  int gapCycles;
  int releases;
  bit haveReleased;
  int grantLog [$];

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic f, input logic [31:0] d);
    @(posedge wr_clk);
    #1;
    bus.req      = r;
    bus.full     = f;
    bus.req_data = d;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [3:0] expAck;
    expAck = v.wr ? v.gnt : 4'b0000;
    nChecks++;
    if (bus.gnt !== v.gnt || bus.ack !== expAck || bus.wr_en !== v.wr ||
        bus.wdata !== v.wdata || bus.busy !== v.busy || bus.grant_id !== v.gid) begin
      nFail++;
      $display("[TB] FAIL vec%0d: got gnt=%b ack=%b wr_en=%b wdata=%h busy=%b gid=%0d, want gnt=%b ack=%b wr_en=%b wdata=%h busy=%b gid=%0d",
               idx, bus.gnt, bus.ack, bus.wr_en, bus.wdata, bus.busy, bus.grant_id,
               v.gnt, expAck, v.wr, v.wdata, v.busy, v.gid);
    end
  endtask

  function automatic logic [31:0] laneData();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = {4'(i), 4'(sent[i])};
    return d;
  endfunction

  function automatic int onehotIdx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic resetMonitor();
    prevGnt      = '0;
    burstAcks    = 0;
    gapCycles    = 0;
    releases     = 0;
    haveReleased = 0;
    grantLog.delete();
    for (int i = 0; i < 4; i++) sent[i] = 0;
  endtask

  // One cycle of held-request traffic with the producer model and ownership monitor.
  task automatic step(input logic [3:0] r, input logic f);
    logic [3:0] g;
    logic [3:0] a;
    int k;
    applyStimulus(r, f, laneData());
    #1;
    g = bus.gnt;
    a = bus.ack;
    checkEq("no_write_when_full", 32'(bus.wr_en & f), 0);
    checkEq("busy_matches_gnt", 32'(bus.busy), 32'(g != 0));
    if (bus.wr_en) begin
      k = onehotIdx(a);
      checkEq("ack_matches_gnt", 32'(a), 32'(g));
      if (k >= 0) checkEq("wdata_order", 32'(bus.wdata), 32'({4'(k), 4'(sent[k])}));
    end else begin
      checkEq("ack_zero_without_write", 32'(a), 0);
    end
    if (g != 0 && prevGnt == 0) begin
      grantLog.push_back(onehotIdx(g));
      if (haveReleased) checkEq("handover_gap", gapCycles, 1);
      burstAcks = 0;
    end
    if (g == 0 && prevGnt != 0) begin
      releases++;
      haveReleased = 1;
      checkEq("burst_len", burstAcks, 4);
      gapCycles = 0;
    end
    if (g == 0) gapCycles++;
    if (a != 0) begin
      burstAcks++;
      sent[onehotIdx(a)]++;
    end
    prevGnt = g;
  endtask

  task automatic runUntil(input logic [3:0] r, input bit toggle, input int target, input int budget);
    logic f;
    int n;
    f = 1'b0;
    n = 0;
    while (releases < target && n < budget) begin
      step(r, toggle ? f : 1'b0);
      f = ~f;
      n++;
    end
    checkEq("release_budget", releases, target);
  endtask

  // Owner left granted by the idle-cycle arbitration is released without writes.
  task automatic drainIdle();
    applyStimulus(4'b0000, 1'b0, laneData());
    applyStimulus(4'b0000, 1'b0, laneData());
    #1;
    checkEq("drain_idle", 32'(bus.busy), 0);
    prevGnt      = '0;
    gapCycles    = 0;
    haveReleased = 0;
    grantLog.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t tbl [25];
  int s0, s2;

  initial begin
    tbl = '{
      '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0010, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0010, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0011, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0012, 4'b0001, 1'b1, 8'h12, 1'b1, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0013, 4'b0001, 1'b1, 8'h13, 1'b1, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0014, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0014, 4'b0001, 1'b1, 8'h14, 1'b1, 2'd0},
      '{4'b0000, 1'b0, 32'h0000_0015, 4'b0001, 1'b0, 8'h15, 1'b1, 2'd0},
      '{4'b0000, 1'b0, 32'h0000_0015, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0},
      '{4'b0100, 1'b0, 32'h00A0_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0},
      '{4'b0100, 1'b0, 32'h00A0_0000, 4'b0100, 1'b1, 8'hA0, 1'b1, 2'd2},
      '{4'b0100, 1'b0, 32'h00A1_0000, 4'b0100, 1'b1, 8'hA1, 1'b1, 2'd2},
      '{4'b0000, 1'b0, 32'h00A2_0000, 4'b0100, 1'b0, 8'hA2, 1'b1, 2'd2},
      '{4'b0000, 1'b0, 32'h00A2_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2},
      '{4'b1001, 1'b0, 32'h4000_0020, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2},
      '{4'b1001, 1'b0, 32'h4000_0020, 4'b1000, 1'b1, 8'h40, 1'b1, 2'd3},
      '{4'b1001, 1'b1, 32'h4100_0020, 4'b1000, 1'b0, 8'h41, 1'b1, 2'd3},
      '{4'b1001, 1'b0, 32'h4100_0020, 4'b1000, 1'b1, 8'h41, 1'b1, 2'd3},
      '{4'b0001, 1'b0, 32'h4200_0020, 4'b1000, 1'b0, 8'h42, 1'b1, 2'd3},
      '{4'b0001, 1'b0, 32'h0000_0020, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3},
      '{4'b0001, 1'b1, 32'h0000_0020, 4'b0001, 1'b0, 8'h20, 1'b1, 2'd0},
      '{4'b0001, 1'b0, 32'h0000_0020, 4'b0001, 1'b1, 8'h20, 1'b1, 2'd0},
      '{4'b0000, 1'b0, 32'h0000_0000, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0},
      '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0}
    };

    rst          = 1'b1;
    bus.req      = '0;
    bus.full     = 1'b0;
    bus.req_data = '0;
    resetMonitor();

    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    checkEq("reset_gnt", 32'(bus.gnt), 0);
    checkEq("reset_busy", 32'(bus.busy), 0);
    checkEq("reset_wr_en", 32'(bus.wr_en), 0);
    checkEq("reset_grant_id", 32'(bus.grant_id), 0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i].req, tbl[i].full, tbl[i].data);
      #1;
      checkOutput(i, tbl[i]);
    end

    // Reset in the middle of an owned burst, then a fresh full burst.
    resetMonitor();
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    rst = 1'b1;
    #1;
    checkEq("midburst_rst_gnt", 32'(bus.gnt), 0);
    checkEq("midburst_rst_wr_en", 32'(bus.wr_en), 0);
    checkEq("midburst_rst_busy", 32'(bus.busy), 0);
    checkEq("midburst_rst_ack", 32'(bus.ack), 0);
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
    resetMonitor();
    runUntil(4'b0010, 1'b0, 1, 20);
    checkEq("regrant_after_reset", grantLog.size() > 0 ? grantLog[0] : -1, 1);
    drainIdle();

    // Full contention: owner 1 just released, so the scan starts at 2.
    runUntil(4'b1111, 1'b0, 6, 60);
    checkEq("rr_order_len", grantLog.size(), 5);
    if (grantLog.size() == 5) begin
      checkEq("rr_order0", grantLog[0], 2);
      checkEq("rr_order1", grantLog[1], 3);
      checkEq("rr_order2", grantLog[2], 0);
      checkEq("rr_order3", grantLog[3], 1);
      checkEq("rr_order4", grantLog[4], 2);
    end
    drainIdle();

    // Two producers with full toggling every cycle; rr_ptr is 0 after the drain.
    s0 = sent[0];
    s2 = sent[2];
    runUntil(4'b0101, 1'b1, 10, 200);
    checkEq("toggle_order_len", grantLog.size(), 4);
    if (grantLog.size() == 4) begin
      checkEq("toggle_order0", grantLog[0], 0);
      checkEq("toggle_order1", grantLog[1], 2);
      checkEq("toggle_order2", grantLog[2], 0);
      checkEq("toggle_order3", grantLog[3], 2);
    end
    checkEq("toggle_beats_p0", sent[0] - s0, 8);
    checkEq("toggle_beats_p2", sent[2] - s2, 8);
    drainIdle();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end
endmodule
